hog_operand_loader: RTL and testbench

//  Producer side of the 64-input FP adder tree. It collects a stream of 32-bit IEEE-754

---
 rtl/hog_pkg.sv | 18 +
 rtl/hog_operand_loader_if.sv | 12 +
 rtl/hog_valid_delay.sv | 38 +++
 rtl/hog_operand_loader.sv | 118 +++++++++++
 tb/tb_hog_operand_loader.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hog_pkg.sv
// rtl/hog_pkg.sv - shared constants and state encoding for the HOG operand loader
package hog_pkg;

    localparam int N_OPS    = 64;
    localparam int TREE_LAT = 6;
    localparam int TAG_W    = 4;
    localparam int CNT_W    = $clog2(N_OPS + 1);
    localparam int IDX_W    = $clog2(N_OPS);

    localparam logic [31:0] FP32_ZERO = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_DRAIN  = 2'd2
    } state_e;

endpackage

// File: rtl/hog_operand_loader_if.sv
// rtl/hog_operand_loader_if.sv - operand input stream into the loader
interface hog_operand_loader_if;

    logic [31:0] iData;
    logic        iValid;
    logic        iLast;
    logic        oReady;

    modport master (output iData, output iValid, output iLast, input  oReady);
    modport slave  (input  iData, input  iValid, input  iLast, output oReady);

endinterface

// File: rtl/hog_valid_delay.sv
// rtl/hog_valid_delay.sv - {valid,tag} shift line that tracks launches through the adder tree
module hog_valid_delay #(
    parameter int DEPTH = 6,
    parameter int TAG_W = 4
) (
    input  logic             iClk,
    input  logic             iRst_n,
    input  logic             iValid,
    input  logic [TAG_W-1:0] iTag,
    output logic             oValid,
    output logic [TAG_W-1:0] oTag,
    output logic             oPending
);

    logic [DEPTH-1:0] vld_q;
    logic [TAG_W-1:0] tag_q [DEPTH];

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            vld_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            vld_q    <= {vld_q[DEPTH-2:0], iValid};
            tag_q[0] <= iTag;
            for (int i = 1; i < DEPTH; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign oValid = vld_q[DEPTH-1];
    assign oTag   = tag_q[DEPTH-1];
    // Excludes the tail: an entry presenting its sum this cycle is already delivered.
    assign oPending = |vld_q[DEPTH-2:0];

endmodule

// File: rtl/hog_operand_loader.sv
// rtl/hog_operand_loader.sv - collects FP32 products into a 64-word bank and launches it to the adder tree
// Optional build macro HOG_LOADER_ZERO_PAD_EN: iLast launches a short bank padded with +0.0.
module hog_operand_loader #(
    parameter int TREE_LAT = hog_pkg::TREE_LAT,
    parameter int TAG_W    = hog_pkg::TAG_W
) (
    input  logic                         iClk,
    input  logic                         iRst_n,
    hog_operand_loader_if.slave          op_if,
    input  logic                         iFlush,
    output logic [32*hog_pkg::N_OPS-1:0] oOps,
    output logic                         oLaunch,
    output logic                         oSumValid,
    output logic [TAG_W-1:0]             oSumTag,
    output logic                         oBusy
);

    import hog_pkg::*;

    state_e                 state_q;
    logic [CNT_W-1:0]       count_q;
    logic [31:0]            fill_q [N_OPS];
    logic [32*N_OPS-1:0]    ops_q;
    logic                   launch_q;
    logic [TAG_W-1:0]       tag_cnt_q;
    logic [TAG_W-1:0]       launch_tag_q;
    logic                   rdy_en_q;
    logic                   xfer;
    logic                   last_word;
    logic                   line_pending;
    logic                   pending;

    // rdy_en_q keeps oReady low until the first clock after reset release.
    assign op_if.oReady = rdy_en_q && (state_q == ST_FILL);
    assign xfer         = op_if.iValid && op_if.oReady;

`ifdef HOG_LOADER_ZERO_PAD_EN
    assign last_word = (count_q == CNT_W'(N_OPS - 1)) || op_if.iLast;
`else
    assign last_word = (count_q == CNT_W'(N_OPS - 1));
`endif

    always_ff @(posedge iClk) begin
        if (xfer) begin
            fill_q[count_q[IDX_W-1:0]] <= op_if.iData;
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q      <= ST_FILL;
            count_q      <= '0;
            ops_q        <= '0;
            launch_q     <= 1'b0;
            tag_cnt_q    <= '0;
            launch_tag_q <= '0;
            rdy_en_q     <= 1'b0;
        end else begin
            rdy_en_q <= 1'b1;
            launch_q <= 1'b0;
            case (state_q)
                ST_FILL: begin
                    // A bank-completing transfer beats a simultaneous flush.
                    if (xfer && last_word) begin
                        count_q <= count_q + 1'b1;
                        state_q <= ST_LAUNCH;
                    end else if (iFlush) begin
                        count_q <= '0;
                        state_q <= ST_DRAIN;
                    end else if (xfer) begin
                        count_q <= count_q + 1'b1;
                    end
                end
                ST_LAUNCH: begin
                    for (int k = 0; k < N_OPS; k++) begin
`ifdef HOG_LOADER_ZERO_PAD_EN
                        ops_q[32*k +: 32] <= (CNT_W'(k) < count_q) ? fill_q[k] : FP32_ZERO;
`else
                        ops_q[32*k +: 32] <= fill_q[k];
`endif
                    end
                    launch_q     <= 1'b1;
                    launch_tag_q <= tag_cnt_q;
                    tag_cnt_q    <= tag_cnt_q + 1'b1;
                    count_q      <= '0;
                    state_q      <= ST_FILL;
                end
                ST_DRAIN: begin
                    if (!pending) begin
                        state_q <= ST_FILL;
                    end
                end
                default: begin
                    state_q <= ST_FILL;
                end
            endcase
        end
    end

    hog_valid_delay #(
        .DEPTH (TREE_LAT),
        .TAG_W (TAG_W)
    ) u_valid_delay (
        .iClk     (iClk),
        .iRst_n   (iRst_n),
        .iValid   (launch_q),
        .iTag     (launch_tag_q),
        .oValid   (oSumValid),
        .oTag     (oSumTag),
        .oPending (line_pending)
    );

    assign pending = launch_q || line_pending;
    assign oOps    = ops_q;
    assign oLaunch = launch_q;
    assign oBusy   = (state_q != ST_FILL) || pending || oSumValid;

endmodule

// File: tb/tb_hog_operand_loader.sv
// tb/tb_hog_operand_loader.sv - directed self-checking bench for hog_operand_loader
module tb_hog_operand_loader;

  logic          iClk;
  logic          iRst_n;
  logic          iFlush;
  logic [2047:0] oOps;
  logic          oLaunch;
  logic          oSumValid;
  logic [3:0]    oSumTag;
  logic          oBusy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int launch_cyc[$];
  int sum_cyc[$];
  logic [3:0] sum_tag[$];

  hog_operand_loader_if op_if ();

  hog_operand_loader dut (
    .iClk      (iClk),
    .iRst_n    (iRst_n),
    .op_if     (op_if),
    .iFlush    (iFlush),
    .oOps      (oOps),
    .oLaunch   (oLaunch),
    .oSumValid (oSumValid),
    .oSumTag   (oSumTag),
    .oBusy     (oBusy)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  always @(posedge iClk) cyc <= cyc + 1;

  always @(negedge iClk) begin
    if (oLaunch) launch_cyc.push_back(cyc);
    if (oSumValid) begin
      sum_cyc.push_back(cyc);
      sum_tag.push_back(oSumTag);
    end
  end

  // Small positive integer -> IEEE-754 single bits.
  function automatic logic [31:0] fp_of(input int n);
    int e;
    e = 0;
    while ((n >> (e + 1)) != 0) e++;
    return {1'b0, 8'(127 + e), 23'((n << (23 - e)) & 32'h7f_ffff)};
  endfunction

  function automatic logic [31:0] slot(input int k);
    return oOps[32*k +: 32];
  endfunction

  task automatic do_reset();
    iRst_n = 1'b0;
    iFlush = 1'b0;
    op_if.iValid = 1'b0;
    op_if.iLast = 1'b0;
    op_if.iData = '0;
    @(negedge iClk);
    @(negedge iClk);
    iRst_n = 1'b1;
    @(posedge iClk);
    #1;
    launch_cyc.delete();
    sum_cyc.delete();
    sum_tag.delete();
  endtask

  task automatic push_word(input logic [31:0] d, input logic last, input logic flush);
    int n;
    op_if.iData = d;
    op_if.iValid = 1'b1;
    op_if.iLast = last;
    iFlush = flush;
    n = 0;
    @(negedge iClk);
    while (!op_if.oReady && n < 200) begin
      n++;
      @(negedge iClk);
    end
    if (!op_if.oReady) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: oReady=%b required 1 within 200 cycles", op_if.oReady);
    end
    @(posedge iClk);
    #1;
    op_if.iValid = 1'b0;
    op_if.iLast = 1'b0;
    iFlush = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge iClk);
      #1;
    end
  endtask

  task automatic test_reset();
    iRst_n = 1'b0;
    iFlush = 1'b0;
    op_if.iValid = 1'b0;
    op_if.iLast = 1'b0;
    op_if.iData = '0;
    #3;
    checks++;
    if ({|oOps, oLaunch, oSumValid, oSumTag, oBusy, op_if.oReady} !== 9'b0) begin
      errors++;
      $display("FAIL reset_outputs: ops_nz=%b launch=%b sv=%b tag=%0d busy=%b rdy=%b required all 0",
               |oOps, oLaunch, oSumValid, oSumTag, oBusy, op_if.oReady);
    end
    @(negedge iClk);
    iRst_n = 1'b1;
    checks++;
    if (op_if.oReady !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready_low: oReady=%b required 0 before first clock", op_if.oReady);
    end
    @(posedge iClk);
    #1;
    checks++;
    if (op_if.oReady !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready_rise: oReady=%b required 1", op_if.oReady);
    end
  endtask

  task automatic test_full_bank();
    int bad;
    do_reset();
    for (int k = 0; k < 64; k++) push_word(fp_of(k + 1), 1'b0, 1'b0);
    @(negedge iClk);
    checks++;
    if ({op_if.oReady, oLaunch, oBusy} !== 3'b001) begin
      errors++;
      $display("FAIL launch_state: rdy/launch/busy=%b required 001", {op_if.oReady, oLaunch, oBusy});
    end
    @(posedge iClk);
    #1;
    checks++;
    if ({oLaunch, op_if.oReady} !== 2'b11) begin
      errors++;
      $display("FAIL launch_pulse: launch/rdy=%b required 11", {oLaunch, op_if.oReady});
    end
    checks++;
    if (slot(0) !== 32'h3f80_0000 || slot(63) !== 32'h4280_0000) begin
      errors++;
      $display("FAIL slot_0_63: %h/%h required 3f800000/42800000", slot(0), slot(63));
    end
    bad = 0;
    for (int k = 0; k < 64; k++) if (slot(k) !== fp_of(k + 1)) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bank_content: %0d slots wrong required 0", bad);
    end
    for (int i = 1; i <= 7; i++) begin
      @(posedge iClk);
      #1;
      checks++;
      if (oSumValid !== (i == 6)) begin
        errors++;
        $display("FAIL sum_valid_t%0d: oSumValid=%b required %b", i, oSumValid, i == 6);
      end
    end
    checks++;
    if (sum_tag.size() != 1 || sum_tag[0] !== 4'd0) begin
      errors++;
      $display("FAIL sum_tag0: count=%0d required 1 with tag 0", sum_tag.size());
    end
    checks++;
    if (oBusy !== 1'b0) begin
      errors++;
      $display("FAIL busy_idle: oBusy=%b required 0", oBusy);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int k = 0; k < 128; k++) push_word(32'h4000_0000 + k, 1'b0, 1'b0);
    idle(10);
    checks++;
    if (launch_cyc.size() != 2 || sum_cyc.size() != 2) begin
      errors++;
      $display("FAIL b2b_counts: launches=%0d sums=%0d required 2/2", launch_cyc.size(), sum_cyc.size());
    end else begin
      checks++;
      if (launch_cyc[1] - launch_cyc[0] != 65) begin
        errors++;
        $display("FAIL b2b_launch_gap: %0d required 65", launch_cyc[1] - launch_cyc[0]);
      end
      checks++;
      if (sum_cyc[0] - launch_cyc[0] != 6 || sum_cyc[1] - sum_cyc[0] != 65) begin
        errors++;
        $display("FAIL b2b_sum_timing: lat=%0d gap=%0d required 6/65",
                 sum_cyc[0] - launch_cyc[0], sum_cyc[1] - sum_cyc[0]);
      end
      checks++;
      if (sum_tag[0] !== 4'd0 || sum_tag[1] !== 4'd1) begin
        errors++;
        $display("FAIL b2b_tags: %0d,%0d required 0,1", sum_tag[0], sum_tag[1]);
      end
    end
  endtask

  task automatic test_gated_valid();
    logic [31:0] exp_w [64];
    int bad;
    do_reset();
    for (int k = 0; k < 64; k++) begin
      exp_w[k] = 32'ha500_0000 ^ (k * 32'h0001_0203);
      repeat ($urandom_range(0, 1)) idle(1);
      push_word(exp_w[k], 1'b0, 1'b0);
    end
    @(posedge iClk);
    #1;
    checks++;
    if (oLaunch !== 1'b1) begin
      errors++;
      $display("FAIL gated_launch: oLaunch=%b required 1", oLaunch);
    end
    bad = 0;
    for (int k = 0; k < 64; k++) if (slot(k) !== exp_w[k]) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL gated_order: %0d slots wrong required 0", bad);
    end
    bad = 0;
    for (int j = 0; j < 20; j++) begin
      repeat ($urandom_range(0, 1)) idle(1);
      push_word(32'h1234_0000 + j, 1'b0, 1'b0);
      for (int k = 0; k < 64; k++) if (slot(k) !== exp_w[k]) bad++;
    end
    checks++;
    if (bad != 0 || launch_cyc.size() != 1) begin
      errors++;
      $display("FAIL gated_hold: %0d slot changes, %0d launches required 0/1", bad, launch_cyc.size());
    end
  endtask

  task automatic test_flush();
    int l;
    do_reset();
    for (int k = 0; k < 64; k++) push_word(fp_of(k + 1), 1'b0, 1'b0);
    @(posedge iClk);
    #1;
    l = cyc;
    for (int k = 0; k < 3; k++) push_word(32'hdead_0000 + k, 1'b0, 1'b0);
    iFlush = 1'b1;
    @(posedge iClk);
    #1;
    iFlush = 1'b0;
    checks++;
    if (oBusy !== 1'b1) begin
      errors++;
      $display("FAIL flush_busy: oBusy=%b required 1", oBusy);
    end
    for (int c = l + 4; c <= l + 8; c++) begin
      checks++;
      if (op_if.oReady !== (c >= l + 7) || oSumValid !== (c == l + 6)) begin
        errors++;
        $display("FAIL flush_drain_c%0d: rdy=%b sv=%b required %b/%b",
                 c - l, op_if.oReady, oSumValid, c >= l + 7, c == l + 6);
      end
      if (c < l + 8) idle(1);
    end
    for (int k = 0; k < 64; k++) push_word(fp_of(k + 100), 1'b0, 1'b0);
    @(posedge iClk);
    #1;
    checks++;
    if (oLaunch !== 1'b1 || slot(0) !== fp_of(100) || slot(63) !== fp_of(163)) begin
      errors++;
      $display("FAIL flush_restart: launch=%b s0=%h s63=%h required 1/%h/%h",
               oLaunch, slot(0), slot(63), fp_of(100), fp_of(163));
    end
    idle(8);
    iFlush = 1'b1;
    @(posedge iClk);
    #1;
    iFlush = 1'b0;
    checks++;
    if ({op_if.oReady, oBusy} !== 2'b01) begin
      errors++;
      $display("FAIL flush_idle_drain: rdy/busy=%b required 01", {op_if.oReady, oBusy});
    end
    @(posedge iClk);
    #1;
    checks++;
    if ({op_if.oReady, oBusy} !== 2'b10) begin
      errors++;
      $display("FAIL flush_idle_exit: rdy/busy=%b required 10", {op_if.oReady, oBusy});
    end
    for (int k = 0; k < 63; k++) push_word(32'h0bad_0000 + k, 1'b0, 1'b0);
    push_word(32'h0bad_003f, 1'b0, 1'b1);
    checks++;
    if (op_if.oReady !== 1'b0) begin
      errors++;
      $display("FAIL flush_vs_64th_state: oReady=%b required 0 (LAUNCH)", op_if.oReady);
    end
    @(posedge iClk);
    #1;
    checks++;
    if (oLaunch !== 1'b1 || slot(63) !== 32'h0bad_003f) begin
      errors++;
      $display("FAIL flush_vs_64th_launch: launch=%b s63=%h required 1/0bad003f", oLaunch, slot(63));
    end
  endtask

  task automatic test_zero_pad();
    int bad;
    do_reset();
    for (int k = 0; k < 64; k++) push_word(32'hffff_0000 + k, 1'b0, 1'b0);
    idle(10);
    launch_cyc.delete();
    sum_cyc.delete();
    for (int k = 0; k < 5; k++) push_word(fp_of(k + 1), k == 4, 1'b0);
`ifdef HOG_LOADER_ZERO_PAD_EN
    @(posedge iClk);
    #1;
    checks++;
    if (oLaunch !== 1'b1) begin
      errors++;
      $display("FAIL zp_launch: oLaunch=%b required 1", oLaunch);
    end
    bad = 0;
    for (int k = 0; k < 5; k++) if (slot(k) !== fp_of(k + 1)) bad++;
    for (int k = 5; k < 64; k++) if (slot(k) !== 32'h0000_0000) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL zp_slots: %0d slots wrong required 0", bad);
    end
    idle(7);
    checks++;
    if (sum_cyc.size() != 1 || launch_cyc.size() != 1) begin
      errors++;
      $display("FAIL zp_sum: sums=%0d launches=%0d required 1/1", sum_cyc.size(), launch_cyc.size());
    end else begin
      checks++;
      if (sum_cyc[0] - launch_cyc[0] != 6) begin
        errors++;
        $display("FAIL zp_sum_lat: %0d required 6", sum_cyc[0] - launch_cyc[0]);
      end
    end
`else
    idle(4);
    checks++;
    if (launch_cyc.size() != 0 || op_if.oReady !== 1'b1) begin
      errors++;
      $display("FAIL nozp_no_launch: launches=%0d rdy=%b required 0/1", launch_cyc.size(), op_if.oReady);
    end
    for (int k = 5; k < 64; k++) push_word(fp_of(k + 1), 1'b0, 1'b0);
    @(posedge iClk);
    #1;
    bad = 0;
    for (int k = 0; k < 64; k++) if (slot(k) !== fp_of(k + 1)) bad++;
    checks++;
    if (oLaunch !== 1'b1 || bad != 0) begin
      errors++;
      $display("FAIL nozp_full: launch=%b bad_slots=%0d required 1/0", oLaunch, bad);
    end
`endif
  endtask

  task automatic test_reset_mid_flight();
    do_reset();
    for (int k = 0; k < 64; k++) push_word(fp_of(k + 1), 1'b0, 1'b0);
    @(posedge iClk);
    #1;
    for (int k = 0; k < 3; k++) push_word(32'h7777_0000 + k, 1'b0, 1'b0);
    #2;
    iRst_n = 1'b0;
    #1;
    checks++;
    if ({|oOps, oLaunch, oSumValid, oSumTag, oBusy, op_if.oReady} !== 9'b0) begin
      errors++;
      $display("FAIL midrst_outputs: ops_nz=%b launch=%b sv=%b tag=%0d busy=%b rdy=%b required all 0",
               |oOps, oLaunch, oSumValid, oSumTag, oBusy, op_if.oReady);
    end
    sum_cyc.delete();
    sum_tag.delete();
    launch_cyc.delete();
    @(negedge iClk);
    @(negedge iClk);
    iRst_n = 1'b1;
    idle(12);
    checks++;
    if (sum_cyc.size() != 0 || launch_cyc.size() != 0) begin
      errors++;
      $display("FAIL midrst_lost: sums=%0d launches=%0d required 0/0", sum_cyc.size(), launch_cyc.size());
    end
    for (int k = 0; k < 64; k++) push_word(fp_of(k + 1), 1'b0, 1'b0);
    idle(9);
    checks++;
    if (sum_tag.size() != 1 || sum_tag[0] !== 4'd0) begin
      errors++;
      $display("FAIL midrst_tag: sums=%0d required 1 with tag 0", sum_tag.size());
    end
  endtask

  initial begin
    test_reset();
    test_full_bank();
    test_back_to_back();
    test_gated_valid();
    test_flush();
    test_zero_pad();
    test_reset_mid_flight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
